// File: rtl/xo_board_ctrl.sv
// rtl/xo_board_ctrl.sv - XO board game-state controller with registered pixel lookup
module xo_board_ctrl #(
  parameter int unsigned BOARD_X    = 87,
  parameter int unsigned BOARD_Y    = 60,
  parameter int unsigned CELL_W     = 155,
  parameter int unsigned CELL_H     = 120,
  parameter int unsigned MARK_Y_OFF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_place,
  input  logic [9:0]  scan_x,
  input  logic [8:0]  scan_y,
  output logic [9:0]  mark_x,
  output logic [8:0]  mark_y,
  output logic [1:0]  cell_mark,
  output logic        in_board,
  output logic        cursor_hit,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'b00,
    S_CHECK = 2'b01,
    S_WIN   = 2'b10,
    S_DRAW  = 2'b11
  } state_e;

  // Cell boundaries and glyph origins, precomputed so the beam lookup is compare-only.
  localparam logic [9:0] X0  = 10'(BOARD_X);
  localparam logic [9:0] X1  = 10'(BOARD_X + CELL_W);
  localparam logic [9:0] X2  = 10'(BOARD_X + 2 * CELL_W);
  localparam logic [9:0] X3  = 10'(BOARD_X + 3 * CELL_W);
  localparam logic [8:0] Y0  = 9'(BOARD_Y);
  localparam logic [8:0] Y1  = 9'(BOARD_Y + CELL_H);
  localparam logic [8:0] Y2  = 9'(BOARD_Y + 2 * CELL_H);
  localparam logic [8:0] Y3  = 9'(BOARD_Y + 3 * CELL_H);
  localparam logic [8:0] MY0 = 9'(BOARD_Y + MARK_Y_OFF);
  localparam logic [8:0] MY1 = 9'(BOARD_Y + CELL_H + MARK_Y_OFF);
  localparam logic [8:0] MY2 = 9'(BOARD_Y + 2 * CELL_H + MARK_Y_OFF);

  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'd3) + {2'b00, c};
  endfunction

  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
  endfunction

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  cur_row_q, cur_row_d, cur_col_q, cur_col_d;

  logic [9:0]  mark_x_q;
  logic [8:0]  mark_y_q;
  logic [1:0]  cell_mark_q;
  logic        in_board_q, cursor_hit_q;

  logic [1:0]  pix_col, pix_row;
  logic        pix_in;
  logic [3:0]  pix_idx, cur_idx;
  logic [1:0]  lm [8];
  logic [1:0]  win_mark;
  logic        full;

  // Resolve the cell under the beam from the scan position.
  always_comb begin
    pix_col = (scan_x < X1) ? 2'd0 : (scan_x < X2) ? 2'd1 : 2'd2;
    pix_row = (scan_y < Y1) ? 2'd0 : (scan_y < Y2) ? 2'd1 : 2'd2;
    pix_in  = (scan_x >= X0) && (scan_x < X3) && (scan_y >= Y0) && (scan_y < Y3);
    pix_idx = cell_idx(pix_row, pix_col);
    cur_idx = cell_idx(cur_row_q, cur_col_q);
  end

  // Register the glyph origin, occupancy and cursor flag for the renderers.
  always_ff @(posedge clk) begin
    if (reset || !pix_in) begin
      in_board_q   <= 1'b0;
      mark_x_q     <= '0;
      mark_y_q     <= '0;
      cell_mark_q  <= 2'b00;
      cursor_hit_q <= 1'b0;
    end else begin
      in_board_q   <= 1'b1;
      mark_x_q     <= (pix_col == 2'd0) ? X0 : (pix_col == 2'd1) ? X1 : X2;
      mark_y_q     <= (pix_row == 2'd0) ? MY0 : (pix_row == 2'd1) ? MY1 : MY2;
      cell_mark_q  <= board_q[{pix_idx, 1'b0} +: 2];
      cursor_hit_q <= (pix_row == cur_row_q) && (pix_col == cur_col_q);
    end
  end

  // Evaluate the eight lines and board fullness on the current board.
  always_comb begin
    lm[0] = line3(board_q[1:0],   board_q[3:2],   board_q[5:4]);
    lm[1] = line3(board_q[7:6],   board_q[9:8],   board_q[11:10]);
    lm[2] = line3(board_q[13:12], board_q[15:14], board_q[17:16]);
    lm[3] = line3(board_q[1:0],   board_q[7:6],   board_q[13:12]);
    lm[4] = line3(board_q[3:2],   board_q[9:8],   board_q[15:14]);
    lm[5] = line3(board_q[5:4],   board_q[11:10], board_q[17:16]);
    lm[6] = line3(board_q[1:0],   board_q[9:8],   board_q[17:16]);
    lm[7] = line3(board_q[5:4],   board_q[9:8],   board_q[13:12]);
    win_mark = 2'b00;
    for (int i = 0; i < 8; i++) begin
      if (win_mark == 2'b00) win_mark = lm[i];
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_q[2*i +: 2] == 2'b00) full = 1'b0;
    end
  end

  // Next-state logic: placement, cursor moves, result evaluation and new game.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    case (state_q)
      S_PLAY: begin
        if (btn_place) begin
          if (board_q[{cur_idx, 1'b0} +: 2] == 2'b00) begin
            board_d[{cur_idx, 1'b0} +: 2] = turn_q ? 2'b10 : 2'b01;
            state_d = S_CHECK;
          end
        end else begin
          if (btn_up && !btn_down && cur_row_q != 2'd0)         cur_row_d = cur_row_q - 2'd1;
          else if (btn_down && !btn_up && cur_row_q != 2'd2)    cur_row_d = cur_row_q + 2'd1;
          if (btn_left && !btn_right && cur_col_q != 2'd0)      cur_col_d = cur_col_q - 2'd1;
          else if (btn_right && !btn_left && cur_col_q != 2'd2) cur_col_d = cur_col_q + 2'd1;
        end
      end
      S_CHECK: begin
        if (win_mark != 2'b00) begin
          state_d  = S_WIN;
          winner_d = win_mark;
        end else if (full) begin
          state_d  = S_DRAW;
          winner_d = 2'b00;
        end else begin
          state_d = S_PLAY;
          turn_d  = ~turn_q;
        end
      end
      default: begin
        if (btn_place) begin
          board_d   = '0;
          winner_d  = 2'b00;
          turn_d    = 1'b0;
          cur_row_d = 2'd1;
          cur_col_d = 2'd1;
          state_d   = S_PLAY;
        end
      end
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_PLAY;
      board_q   <= '0;
      turn_q    <= 1'b0;
      winner_q  <= 2'b00;
      cur_row_q <= 2'd1;
      cur_col_q <= 2'd1;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
    end
  end

  assign mark_x     = mark_x_q;
  assign mark_y     = mark_y_q;
  assign cell_mark  = cell_mark_q;
  assign in_board   = in_board_q;
  assign cursor_hit = cursor_hit_q;
  assign board      = board_q;
  assign turn       = turn_q;
  assign game_state = state_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_xo_board_ctrl.sv
// tb/tb_xo_board_ctrl.sv - directed self-checking bench for xo_board_ctrl
module tb_xo_board_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_place;
  logic [9:0]  scan_x;
  logic [8:0]  scan_y;
  logic [9:0]  mark_x;
  logic [8:0]  mark_y;
  logic [1:0]  cell_mark;
  logic        in_board;
  logic        cursor_hit;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  game_state;
  logic [1:0]  winner;

  int n_checks = 0;
  int n_pass   = 0;
  int cur_r    = 1;
  int cur_c    = 1;

  xo_board_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_place  (btn_place),
    .scan_x     (scan_x),
    .scan_y     (scan_y),
    .mark_x     (mark_x),
    .mark_y     (mark_y),
    .cell_mark  (cell_mark),
    .in_board   (in_board),
    .cursor_hit (cursor_hit),
    .board      (board),
    .turn       (turn),
    .game_state (game_state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic p);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_place = p;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_place = 0;
  endtask

  task automatic scan(input int x, input int y);
    scan_x = 10'(x);
    scan_y = 9'(y);
    tick();
  endtask

  task automatic probe(input int r, input int c);
    scan(87 + c * 155 + 77, 60 + r * 120 + 60);
  endtask

  task automatic goto_cell(input int r, input int c);
    while (cur_c > c) begin press(0, 0, 1, 0, 0); cur_c--; end
    while (cur_c < c) begin press(0, 0, 0, 1, 0); cur_c++; end
    while (cur_r > r) begin press(1, 0, 0, 0, 0); cur_r--; end
    while (cur_r < r) begin press(0, 1, 0, 0, 0); cur_r++; end
  endtask

  task automatic place_at(input int r, input int c);
    goto_cell(r, c);
    press(0, 0, 0, 0, 1);
    check("enter_check", game_state, 2'b01);
    tick();
  endtask

  initial begin
    reset = 1; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_place = 0;
    scan_x = 10'd250; scan_y = 9'd200;
    tick(); tick();
    check("rst_board", board, 18'h0);
    check("rst_turn", turn, 1'b0);
    check("rst_state", game_state, 2'b00);
    check("rst_winner", winner, 2'b00);
    check("rst_in_board", in_board, 1'b0);
    check("rst_mark_x", mark_x, 10'd0);
    reset = 0;

    scan(250, 200);
    check("px_in_board", in_board, 1'b1);
    check("px_mark_x", mark_x, 10'd242);
    check("px_mark_y", mark_y, 9'd188);
    check("px_cell_mark", cell_mark, 2'b00);
    check("px_cursor_hit", cursor_hit, 1'b1);

    scan(86, 60);
    check("left_edge_in", in_board, 1'b0);
    check("left_edge_mx", mark_x, 10'd0);
    check("left_edge_my", mark_y, 9'd0);
    check("left_edge_cm", cell_mark, 2'b00);
    check("left_edge_ch", cursor_hit, 1'b0);
    scan(552, 300);
    check("right_edge_in", in_board, 1'b0);
    check("right_edge_mx", mark_x, 10'd0);
    scan(87, 60);
    check("corner_in", in_board, 1'b1);
    check("corner_mx", mark_x, 10'd87);
    check("corner_my", mark_y, 9'd68);

    repeat (3) press(0, 0, 1, 0, 0);
    repeat (3) press(1, 0, 0, 0, 0);
    cur_r = 0; cur_c = 0;
    probe(0, 0); check("sat_hit_00", cursor_hit, 1'b1);
    probe(1, 1); check("sat_miss_11", cursor_hit, 1'b0);
    press(0, 0, 1, 1, 0);
    probe(0, 0); check("cancel_lr", cursor_hit, 1'b1);
    press(1, 1, 0, 0, 0);
    probe(0, 0); check("cancel_ud", cursor_hit, 1'b1);
    press(0, 0, 0, 1, 0); cur_c = 1;
    probe(0, 1); check("move_right", cursor_hit, 1'b1);

    place_at(0, 0);
    check("g1_state", game_state, 2'b00);
    check("g1_turn", turn, 1'b1);
    probe(0, 0); check("g1_cell_mark", cell_mark, 2'b01);
    place_at(1, 0);
    check("g2_turn", turn, 1'b0);
    place_at(0, 1);
    place_at(1, 1);
    press(0, 0, 0, 0, 1);
    check("occ_board", board, 18'h00285);
    check("occ_turn", turn, 1'b0);
    check("occ_state", game_state, 2'b00);
    place_at(0, 2);
    check("win_state", game_state, 2'b10);
    check("win_winner", winner, 2'b01);
    check("win_board", board, 18'h00295);
    check("win_turn", turn, 1'b0);
    probe(1, 0); check("win_cell3", cell_mark, 2'b10);
    press(0, 1, 0, 0, 0);
    probe(0, 2); check("win_no_move", cursor_hit, 1'b1);

    press(0, 0, 0, 0, 1);
    cur_r = 1; cur_c = 1;
    check("new_board", board, 18'h0);
    check("new_turn", turn, 1'b0);
    check("new_state", game_state, 2'b00);
    check("new_winner", winner, 2'b00);
    probe(1, 1); check("new_cursor", cursor_hit, 1'b1);

    place_at(0, 0); place_at(0, 1); place_at(0, 2);
    place_at(1, 1); place_at(1, 0); place_at(1, 2);
    place_at(2, 1); place_at(2, 0); place_at(2, 2);
    check("draw_state", game_state, 2'b11);
    check("draw_winner", winner, 2'b00);
    check("draw_board", board, 18'h16A59);

    press(0, 0, 0, 0, 1);
    cur_r = 1; cur_c = 1;
    probe(1, 1);
    press(0, 0, 0, 0, 1);
    check("pre_rst_check", game_state, 2'b01);
    reset = 1;
    tick();
    check("rstc_state", game_state, 2'b00);
    check("rstc_board", board, 18'h0);
    check("rstc_turn", turn, 1'b0);
    check("rstc_winner", winner, 2'b00);
    check("rstc_in_board", in_board, 1'b0);
    check("rstc_cursor_hit", cursor_hit, 1'b0);
    reset = 0;
    probe(1, 1);
    check("rstc_cursor_home", cursor_hit, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
